vmx_axis_result_tx: RTL

//  AXI4-Stream master (transmitter) that drains engine result words from a util_FIFO onto an outbound stream.

---
 rtl/vmx_axis_pkg.sv | 19 +
 rtl/vmx_skid_buf2.sv | 76 +++++++
 rtl/vmx_axis_result_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vmx_axis_pkg.sv
// ---------------------------------------------------------------------------
// vmx_axis_pkg
// Shared definitions for the outbound result stream transmitter:
//   - state_t         : transmitter FSM encoding (IDLE / RUN / FLUSH)
//   - TSTRB_ALL_ONES  : all-ones byte strobe, sliced to the stream width
// ---------------------------------------------------------------------------
package vmx_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Wide enough for a 1024-bit stream; the top slices off what it needs.
    localparam int                        MAX_STRB_WIDTH = 128;
    localparam logic [MAX_STRB_WIDTH-1:0] TSTRB_ALL_ONES = '1;

endpackage

// File: rtl/vmx_skid_buf2.sv
// ---------------------------------------------------------------------------
// vmx_skid_buf2
// Two-entry FIFO carrying {data, last}. Head is presented registered so the
// stream outputs stay stable while the consumer stalls.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears storage too)
//   clr         : synchronous clear of pointers/occupancy (new packet)
//   push        : write push_data/push_last at the tail
//   pop         : retire the head entry
//   head_data   : data of the head entry
//   head_last   : last flag of the head entry
//   occ         : number of buffered entries (0..2)
// ---------------------------------------------------------------------------
module vmx_skid_buf2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] data_mem [2];
    logic [1:0]            last_mem;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_push = push & ((occ != 2'd2) | pop);
    assign do_pop  = pop & (occ != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is reset as well so the head (and hence the
            // stream data/last outputs) read zero straight out of reset.
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
            end
            last_mem <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                data_mem[wr_ptr] <= push_data;
                last_mem[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_last = last_mem[rd_ptr];

endmodule

// File: rtl/vmx_axis_result_tx.sv
// ---------------------------------------------------------------------------
// vmx_axis_result_tx
// AXI4-Stream master that drains engine result words from a util_FIFO and
// sends them as packets of a software-programmed length, TLAST on the final
// beat. A 2-entry output buffer plus read-credit logic gives full rate while
// never over-reading the FIFO when the downstream stalls.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   START, PKT_LEN  : start one packet of PKT_LEN beats (PKT_LEN sampled on START)
//   BUSY, DONE      : packet in progress / 1-cycle completion pulse
//   BEAT_CNT        : beats handshaked in the current/last packet
//   FIFO_DATA       : util_FIFO dout, valid the cycle after FIFO_RDEN
//   FIFO_EMPTY      : util_FIFO empty flag
//   FIFO_RDEN       : util_FIFO read enable
//   M_AXIS_*        : outbound stream (TVALID/TDATA/TSTRB/TLAST/TREADY)
// ---------------------------------------------------------------------------
module vmx_axis_result_tx
    import vmx_axis_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_PKT_LEN_WIDTH      = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              START,
    input  logic [C_PKT_LEN_WIDTH-1:0]        PKT_LEN,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [C_PKT_LEN_WIDTH-1:0]        BEAT_CNT,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   FIFO_DATA,
    input  logic                              FIFO_EMPTY,
    output logic                              FIFO_RDEN,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
);

    localparam logic [C_PKT_LEN_WIDTH-1:0] LEN_ONE = {{(C_PKT_LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                     state;
    state_t                     state_next;
    logic [C_PKT_LEN_WIDTH-1:0] len_q;
    logic [C_PKT_LEN_WIDTH-1:0] req_cnt;
    logic [C_PKT_LEN_WIDTH-1:0] beat_cnt;
    logic                       infl;
    logic                       infl_last;
    logic                       done;
    logic [1:0]                 occ;
    logic                       pop;
    logic                       rden;
    logic                       start_ok;
    logic                       last_hs;
    logic                       credit_ok;
    logic                       buf_clr;

    assign pop      = M_AXIS_TVALID & M_AXIS_TREADY;
    assign last_hs  = pop & M_AXIS_TLAST;
    assign start_ok = START & (PKT_LEN != '0);
    assign buf_clr  = (state == ST_IDLE) & start_ok;

    // occ + infl - pop < 2, rearranged so the unsigned sum cannot underflow.
    // TREADY reaches FIFO_RDEN combinationally; that is what allows a new read
    // every cycle while the buffer is being drained at full rate.
    assign credit_ok = ({1'b0, occ} + {2'b00, infl}) < (3'd2 + {2'b00, pop});

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of block ordering.
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves an output
        // unassigned and no latch is inferred.
        state_next = state;
        rden       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                rden = ~FIFO_EMPTY & (req_cnt < len_q) & credit_ok;
                if (req_cnt == len_q) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (last_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------- counters / pipeline
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q     <= '0;
            req_cnt   <= '0;
            beat_cnt  <= '0;
            infl      <= 1'b0;
            infl_last <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= (state == ST_FLUSH) & last_hs;
            // The FIFO word shows up one cycle after the read, so the read and
            // its last-beat tag are carried alongside it for that cycle.
            infl      <= rden;
            infl_last <= rden & (req_cnt == len_q - LEN_ONE);
            if (buf_clr) begin
                len_q    <= PKT_LEN;
                req_cnt  <= '0;
                beat_cnt <= '0;
            end else begin
                if (rden) begin
                    req_cnt <= req_cnt + LEN_ONE;
                end
                if (pop) begin
                    beat_cnt <= beat_cnt + LEN_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------ output buffer
    vmx_skid_buf2 #(
        .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .clr       (buf_clr),
        .push      (infl),
        .push_data (FIFO_DATA),
        .push_last (infl_last),
        .pop       (pop),
        .head_data (M_AXIS_TDATA),
        .head_last (M_AXIS_TLAST),
        .occ       (occ)
    );

    assign M_AXIS_TVALID = (occ != 2'd0);
    assign M_AXIS_TSTRB  = TSTRB_ALL_ONES[C_M_AXIS_TDATA_WIDTH/8-1:0];
    assign FIFO_RDEN     = rden;
    assign BUSY          = (state != ST_IDLE);
    assign DONE          = done;
    assign BEAT_CNT      = beat_cnt;

endmodule
